// File: rtl/turfio_cout_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : turfio_cout_sched_if
//  Description : Source/sink bundle between the COUT command scheduler and its
//                run-command, trigger, message and training sources, plus the
//                frame outputs toward the serializer.
//  Revision    : 1.0  initial release
// ============================================================================
interface turfio_cout_sched_if;
    logic        train_i;
    logic [1:0]  runcmd_i;
    logic        runcmd_valid_i;
    logic [15:0] trig_addr_i;
    logic        trig_valid_i;
    logic        trig_ready_o;
    logic [23:0] msg_data_i;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic        if_clk_x2_phase_o;
    logic [31:0] cout_command_o;
    logic        cout_train_o;
    logic        runcmd_overflow_o;

    // Source side: drives requests, observes handshakes and the frame outputs
    modport master (
        output train_i, runcmd_i, runcmd_valid_i,
        output trig_addr_i, trig_valid_i, msg_data_i, msg_valid_i,
        input  trig_ready_o, msg_ready_o,
        input  if_clk_x2_phase_o, cout_command_o, cout_train_o, runcmd_overflow_o
    );

    // Scheduler side
    modport slave (
        input  train_i, runcmd_i, runcmd_valid_i,
        input  trig_addr_i, trig_valid_i, msg_data_i, msg_valid_i,
        output trig_ready_o, msg_ready_o,
        output if_clk_x2_phase_o, cout_command_o, cout_train_o, runcmd_overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/turfio_cout_sched.sv
`default_nettype none
// ============================================================================
//  Module      : turfio_cout_sched
//  Description : COUT command-word scheduler on if_clk_x2. Produces the
//                16-cycle frame marker and one 32-bit command word per frame,
//                chosen by strict priority: pending run command > trigger >
//                message > idle. Training forces the idle word and stalls all
//                sources.
//  Revision    : 1.0  initial release
// ============================================================================
module turfio_cout_sched #(
    parameter logic [31:0] IDLE_WORD      = 32'h0000_0000,
    parameter logic        TRAIN_ON_RESET = 1'b1
) (
    input  wire logic           if_clk_x2_i,
    input  wire logic           if_rst_i,
    turfio_cout_sched_if.slave  bus
);

    localparam logic [3:0] FRAME_LAST = 4'hF;
    localparam logic [3:0] TAG_RUNCMD = 4'h1;
    localparam logic [3:0] TAG_TRIG   = 4'h2;
    localparam logic [3:0] TAG_MSG    = 4'h3;

    logic [3:0]  cnt;
    logic [3:0]  seq;
    logic        phase;
    logic [31:0] command;
    logic        train;
    logic        rc_pend;
    logic [1:0]  rc;
    logic        overflow;

    logic        frame_edge;
    logic        training;
    logic        send_rc;
    logic        trig_ready;
    logic        msg_ready;

    // The word is chosen on the last cycle of the frame. Training is in force
    // either because the link is already training or because it is about to
    // start at this very edge; in both cases nothing may be consumed.
    assign frame_edge = (cnt == FRAME_LAST);
    assign training   = train | bus.train_i;
    assign send_rc    = frame_edge & ~training & rc_pend;
    // Reset is folded in so no source sees a transfer while the block is held.
    assign trig_ready = frame_edge & ~training & ~rc_pend & ~if_rst_i;
    assign msg_ready  = trig_ready & ~bus.trig_valid_i;

    assign bus.trig_ready_o      = trig_ready;
    assign bus.msg_ready_o       = msg_ready;
    assign bus.if_clk_x2_phase_o = phase;
    assign bus.cout_command_o    = command;
    assign bus.cout_train_o      = train;
    assign bus.runcmd_overflow_o = overflow;

    // Free-running frame counter; phase is registered so it is high in cycle 0
    always_ff @(posedge if_clk_x2_i) begin
        if (if_rst_i) begin
            cnt   <= 4'd0;
            phase <= 1'b0;
        end else begin
            cnt   <= cnt + 4'd1;
            phase <= frame_edge;
        end
    end

    // Frame-edge update of the command word, training select and sequence number
    always_ff @(posedge if_clk_x2_i) begin
        if (if_rst_i) begin
            command <= IDLE_WORD;
            train   <= TRAIN_ON_RESET;
            seq     <= 4'd0;
        end else if (frame_edge) begin
            train <= bus.train_i;
            if (training) begin
                command <= IDLE_WORD;
            end else if (rc_pend) begin
                command <= {TAG_RUNCMD, seq, 22'd0, rc};
                seq     <= seq + 4'd1;
            end else if (bus.trig_valid_i) begin
                command <= {TAG_TRIG, seq, 8'h00, bus.trig_addr_i};
                seq     <= seq + 4'd1;
            end else if (bus.msg_valid_i) begin
                command <= {TAG_MSG, seq, bus.msg_data_i};
                seq     <= seq + 4'd1;
            end else begin
                command <= IDLE_WORD;
            end
        end
    end

    // Single-entry run-command slot; a new strobe always wins, and a strobe on
    // the edge that ships the old code is a hand-off rather than a loss.
    always_ff @(posedge if_clk_x2_i) begin
        if (if_rst_i) begin
            rc_pend  <= 1'b0;
            rc       <= 2'b00;
            overflow <= 1'b0;
        end else if (bus.runcmd_valid_i) begin
            rc      <= bus.runcmd_i;
            rc_pend <= 1'b1;
            if (rc_pend && !send_rc) begin
                overflow <= 1'b1;
            end
        end else if (send_rc) begin
            rc_pend <= 1'b0;
        end
    end

endmodule
`default_nettype wire
